fetch_unit: RTL and testbench

Instruction fetch stage: owns the program counter, issues word fetches to instruction memory over a valid/ready request channel and collects in-order responses into a small FIFO. It presents `{pc, instr}` pairs to decode, whose instruction register drives the immediate extender and control decoder. A one-cycle redirect from execute (branch/jal target) flushes all in-flight and buffered work and restarts fetch at the new PC.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem valid/ready requests, in-order responses into a decode FIFO.
// Define FETCH_ALIGN_CHECK_EN to halt on misaligned redirect targets (default: low bits forced to 0).
module fetch_unit #(
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned             BUF_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [INSTR_WIDTH-1:0] imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [INSTR_WIDTH-1:0] redirect_pc,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [INSTR_WIDTH-1:0] id_pc,
    output logic                   fetch_misalign
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH = (CW+1)'(BUF_DEPTH);

    logic [INSTR_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0] fifo_pc    [BUF_DEPTH];
    logic [INSTR_WIDTH-1:0] fifo_instr [BUF_DEPTH];
    logic [INSTR_WIDTH-1:0] pcq        [BUF_DEPTH];
    logic [PW-1:0]          f_rd, f_wr, q_rd, q_wr;
    logic [CW-1:0]          fifo_cnt, live_cnt, drop_cnt;
    logic [INSTR_WIDTH-1:0] target;
    logic                   halted;
    logic                   req_fire, rsp_drop, rsp_keep, id_fire;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic {FETCH_RUN, FETCH_HALT} fstate_t;
    fstate_t                fstate;
    logic [INSTR_WIDTH-1:0] halt_pc;

    assign halted         = (fstate == FETCH_HALT);
    assign fetch_misalign = halted;
    assign target         = redirect_pc;
    assign id_pc          = halted ? halt_pc : fifo_pc[f_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate  <= FETCH_RUN;
            halt_pc <= '0;
        end else if (redirect_valid) begin
            fstate  <= (redirect_pc[1:0] != 2'b00) ? FETCH_HALT : FETCH_RUN;
            halt_pc <= redirect_pc;
        end
    end
`else
    assign halted         = 1'b0;
    assign fetch_misalign = 1'b0;
    assign target         = redirect_pc & ~INSTR_WIDTH'(3);
    assign id_pc          = fifo_pc[f_rd];
`endif

    // Issue reserves FIFO space for every kept request, so pushes never overflow.
    assign imem_req_valid = rst_n && !redirect_valid && !halted
                            && (({1'b0, fifo_cnt} + {1'b0, live_cnt}) < DEPTH)
                            && (({1'b0, live_cnt} + {1'b0, drop_cnt}) < DEPTH);
    assign imem_req_addr  = pc;
    assign id_valid       = (fifo_cnt != '0) && !redirect_valid && !halted;
    assign id_instr       = fifo_instr[f_rd];

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && (live_cnt != '0);
    assign id_fire  = id_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            f_rd     <= '0;
            f_wr     <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            fifo_cnt <= '0;
            live_cnt <= '0;
            drop_cnt <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
                pcq[i]        <= '0;
            end
        end else if (redirect_valid) begin
            // Kept requests become dropped; a response this cycle retires one of them.
            pc       <= target;
            f_rd     <= '0;
            f_wr     <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            fifo_cnt <= '0;
            live_cnt <= '0;
            drop_cnt <= drop_cnt + live_cnt
                        - CW'(imem_rsp_valid && ((drop_cnt != '0) || (live_cnt != '0)));
        end else begin
            if (req_fire) begin
                pc        <= pc + INSTR_WIDTH'(4);
                pcq[q_wr] <= pc;
                q_wr      <= q_wr + PW'(1);
            end
            if (rsp_drop)
                drop_cnt <= drop_cnt - CW'(1);
            if (rsp_keep) begin
                fifo_pc[f_wr]    <= pcq[q_rd];
                fifo_instr[f_wr] <= imem_rsp_data;
                f_wr             <= f_wr + PW'(1);
                q_rd             <= q_rd + PW'(1);
            end
            live_cnt <= live_cnt + CW'(req_fire) - CW'(rsp_keep);
            if (id_fire)
                f_rd <= f_rd + PW'(1);
            if (rsp_keep && !id_fire)
                fifo_cnt <= fifo_cnt + CW'(1);
            else if (!rsp_keep && id_fire)
                fifo_cnt <= fifo_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model plus queue-based reference of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          D   = 2;

    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc;
    logic        fetch_misalign;

    fetch_unit #(.INSTR_WIDTH(32), .RESET_PC(RPC), .BUF_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .fetch_misalign(fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, lat = 1, last_due = -1;

    logic [31:0] mq_addr[$];
    int          mq_due[$];

    logic [31:0] m_pc;
    logic [31:0] m_kept[$];
    logic [31:0] m_buf[$];
    int          m_drop;
    bit          m_halt;
    logic [31:0] m_hpc;

    bit          s_req_valid, s_id_valid, s_mis, s_acc;
    logic [31:0] s_req_addr, s_id_pc, s_id_instr;
    logic [31:0] acc_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        m_pc   = RPC;
        m_kept.delete();
        m_buf.delete();
        m_drop = 0;
        m_halt = 0;
        m_hpc  = '0;
        mq_addr.delete();
        mq_due.delete();
    endtask

    task automatic check_and_update();
        bit          e_req, e_idv;
        logic [31:0] tgt;
        int          due;
        e_req = !redirect_valid && !m_halt && (m_buf.size() + m_kept.size() < D)
                && (m_kept.size() + m_drop < D);
        e_idv = (m_buf.size() != 0) && !redirect_valid && !m_halt;
        chk("req_valid", imem_req_valid, e_req);
        if (e_req) chk("req_addr", imem_req_addr, m_pc);
        chk("id_valid", id_valid, e_idv);
        if (e_idv) begin
            chk("id_pc", id_pc, m_buf[0]);
            chk("id_instr", id_instr, mem_word(m_buf[0]));
        end
        chk("fetch_misalign", fetch_misalign, m_halt);
        if (m_halt) chk("halt_id_pc", id_pc, m_hpc);

        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_id_instr  = id_instr;
        s_mis       = fetch_misalign;
        s_acc       = imem_req_valid && imem_req_ready;

        if (redirect_valid) begin
            tgt = redirect_pc;
`ifndef FETCH_ALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            if (imem_rsp_valid && (m_drop + m_kept.size() > 0))
                m_drop = m_drop + m_kept.size() - 1;
            else
                m_drop = m_drop + m_kept.size();
            m_kept.delete();
            m_buf.delete();
            m_pc = tgt;
`ifdef FETCH_ALIGN_CHECK_EN
            m_halt = (tgt[1:0] != 2'b00);
            m_hpc  = tgt;
`endif
        end else begin
            if (e_idv && id_ready) void'(m_buf.pop_front());
            if (imem_rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else if (m_kept.size() > 0) m_buf.push_back(m_kept.pop_front());
            end
            if (e_req && imem_req_ready) begin
                m_kept.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end

        if (imem_rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(due);
        end
        cyc++;
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc, input bit idr, input bit rdy);
        @(posedge clk);
        #1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_ready       = idr;
        imem_req_ready = rdy;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        check_and_update();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        id_ready       = 1'b0;
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_misalign", fetch_misalign, 1'b0);
        @(posedge clk);
        #1;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_valid_held", imem_req_valid, 1'b0);
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        bit          r, found;
        logic [31:0] t;
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        do_reset();

        // reset release, 1-cycle memory, decode always ready
        lat = 1;
        step(0, 0, 1, 1);
        chk("first_req_valid", s_req_valid, 1'b1);
        chk("first_req_addr", s_req_addr, 32'h0000_0100);
        step(0, 0, 1, 1);
        chk("second_req_addr", s_req_addr, 32'h0000_0104);
        step(0, 0, 1, 1);
        chk("first_id_pc", s_id_pc, 32'h0000_0100);
        chk("first_id_instr", s_id_instr, 32'h5B5A_C3C3);
        chk("no_req_when_full", s_req_valid, 1'b0);
        step(0, 0, 1, 1);
        chk("second_id_pc", s_id_pc, 32'h0000_0104);
        chk("second_id_instr", s_id_instr, 32'h5B5E_C3C3);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1);

        // decode stall then release
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        chk("stall_no_req", s_req_valid, 1'b0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1);

        // redirect with two outstanding at latency 3
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        lat = 3;
        step(0, 0, 1, 1);
        chk("lat3_accept0", s_acc, 1'b1);
        step(0, 0, 1, 1);
        chk("lat3_accept1", s_acc, 1'b1);
        step(1, 32'h0000_0200, 1, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 1, 1);
            if (s_id_valid) found = 1;
        end
        if (!found) fail_bound("redirect_first_decode");
        else begin
            chk("redirect_id_pc", s_id_pc, 32'h0000_0200);
            chk("redirect_id_instr", s_id_instr, 32'h585A_C3C3);
        end

        // redirect coinciding with a response
        lat = 1;
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                step(1, 32'h0000_0400, 1, 1);
                chk("redir_rsp_id_valid", s_id_valid, 1'b0);
                step(0, 0, 1, 1);
                chk("redir_rsp_next_valid", s_req_valid, 1'b1);
                chk("redir_rsp_next_addr", s_req_addr, 32'h0000_0400);
                found = 1;
            end else begin
                step(0, 0, 1, 1);
            end
        end
        if (!found) fail_bound("redirect_with_response");
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

        // ready toggling and address wrap
        step(1, 32'hFFFF_FFF8, 1, 0);
        acc_log.delete();
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 1, i[0]);
            if (s_acc) acc_log.push_back(s_req_addr);
        end
        if (acc_log.size() < 3) fail_bound("wrap_accepts");
        else begin
            chk("wrap_acc0", acc_log[0], 32'hFFFF_FFF8);
            chk("wrap_acc1", acc_log[1], 32'hFFFF_FFFC);
            chk("wrap_acc2", acc_log[2], 32'h0000_0000);
        end

        // misaligned redirect
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        step(1, 32'h0000_0202, 1, 1);
        step(0, 0, 1, 1);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_flag", s_mis, 1'b1);
        chk("misalign_no_req", s_req_valid, 1'b0);
        chk("misalign_id_pc", s_id_pc, 32'h0000_0202);
`else
        chk("misalign_flag", s_mis, 1'b0);
        chk("misalign_req_valid", s_req_valid, 1'b1);
        chk("misalign_req_addr", s_req_addr, 32'h0000_0200);
`endif
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        step(1, 32'h0000_0300, 1, 1);
        step(0, 0, 1, 1);
        chk("realign_flag", s_mis, 1'b0);
        chk("realign_req_valid", s_req_valid, 1'b1);
        chk("realign_req_addr", s_req_addr, 32'h0000_0300);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 3) lat = $urandom_range(1, 4);
            r = ($urandom_range(0, 99) < 6);
            t = $urandom;
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            step(r, t, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75);
        end

        // reset in the middle of operation with a non-empty FIFO
        lat = 1;
        step(1, 32'h0000_0800, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(0, 0, 0, 0);
            if (mq_addr.size() == 0) found = 1;
        end
        if (!found) fail_bound("drain_before_reset");
        chk("pre_reset_fifo_valid", s_id_valid, 1'b1);
        do_reset();
        step(0, 0, 1, 1);
        chk("post_reset_req_addr", s_req_addr, 32'h0000_0100);
        for (int i = 0; i < 40; i++) step(0, 0, $urandom_range(0, 1) == 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
